// File: rtl/u_admit_ctrl_if.sv
// Candidate/result handshake bundle for the unary admission controller.
// The slave side is the controller; the master side is the producer plus consumer.
interface u_admit_ctrl_if #(
    parameter int W = 16
);
    localparam int LW = $clog2(W + 1);

    logic          i_in_vld;
    logic [W-1:0]  i_in_x;
    logic          o_in_rdy;
    logic          o_out_vld;
    logic          i_out_rdy;
    logic [W-1:0]  o_out_x;
    logic          o_out_is_unary;
    logic          o_out_is_compl;
    logic [LW-1:0] o_out_len;

    modport master (
        output i_in_vld, i_in_x, i_out_rdy,
        input  o_in_rdy, o_out_vld, o_out_x, o_out_is_unary, o_out_is_compl, o_out_len
    );

    modport slave (
        input  i_in_vld, i_in_x, i_out_rdy,
        output o_in_rdy, o_out_vld, o_out_x, o_out_is_unary, o_out_is_compl, o_out_len
    );
endinterface

// File: rtl/u_admit_ctrl.sv
// Two-stage streaming admission controller for thermometer-coded vectors:
// capture, then classify/decode, with saturating admit/reject statistics.
module u_admit_ctrl #(
    parameter int W                     = 16,
    parameter int P_ADMIT_COMPLIMENT_EN = 1,
    parameter int CNT_W                 = 16
) (
    input  logic             clk,
    input  logic             rst,
    u_admit_ctrl_if.slave    bus,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_cnt_admit,
    output logic [CNT_W-1:0] o_cnt_reject,
    output logic             o_busy
);
    localparam int LW = $clog2(W + 1);

    function automatic logic [LW-1:0] popcount(input logic [W-1:0] x);
        logic [LW-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            n = n + LW'(x[i]);
        end
        return n;
    endfunction

    // Result is {is_unary, is_compl, len}. A value v is (2^k)-1 exactly when
    // v & (v+1) == 0, which also covers k=0 and k=W (wrap to zero).
    function automatic logic [LW+1:0] classify(input logic [W-1:0] x);
        logic [W-1:0]  nx;
        logic [LW+1:0] r;
        nx = ~x;
        r  = '0;
        if (P_ADMIT_COMPLIMENT_EN != 0 && nx == '0) begin
            r = {2'b11, LW'(0)};
        end else if ((x & (x + W'(1))) == '0) begin
            r = {2'b10, popcount(x)};
        end else if (P_ADMIT_COMPLIMENT_EN != 0 && (nx & (nx + W'(1))) == '0) begin
            r = {2'b11, popcount(nx)};
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic          vld_p1;
    logic [W-1:0]  x_p1;
    logic [LW+1:0] cls_p1;
    logic          vld_p2;
    logic [W-1:0]  x_p2;
    logic          unary_p2;
    logic          compl_p2;
    logic [LW-1:0] len_p2;
    logic          ld_p2;
    logic          acc_p1;
    logic          xfer_p2;

    assign ld_p2        = vld_p1 & (~vld_p2 | bus.i_out_rdy);
    assign bus.o_in_rdy = ~vld_p1 | ld_p2;
    assign acc_p1       = bus.i_in_vld & bus.o_in_rdy;
    assign xfer_p2      = vld_p2 & bus.i_out_rdy;
    assign cls_p1       = classify(x_p1);

    // Stage 1: capture
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (acc_p1) begin
            vld_p1 <= 1'b1;
        end else if (ld_p2) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_p1) begin
            x_p1 <= bus.i_in_x;
        end
    end

    // Stage 2: classified result, held until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
        end else if (ld_p2) begin
            vld_p2 <= 1'b1;
        end else if (bus.i_out_rdy) begin
            vld_p2 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_p2) begin
            x_p2     <= x_p1;
            unary_p2 <= cls_p1[LW+1];
            compl_p2 <= cls_p1[LW];
            len_p2   <= cls_p1[LW-1:0];
        end
    end

    // Statistics: a clear beats a coincident delivery
    always_ff @(posedge clk) begin
        if (rst || i_cnt_clr) begin
            o_cnt_admit  <= '0;
            o_cnt_reject <= '0;
        end else if (xfer_p2) begin
            if (unary_p2) begin
                o_cnt_admit <= sat_inc(o_cnt_admit);
            end else begin
                o_cnt_reject <= sat_inc(o_cnt_reject);
            end
        end
    end

    assign bus.o_out_vld      = vld_p2;
    assign bus.o_out_x        = x_p2;
    assign bus.o_out_is_unary = unary_p2;
    assign bus.o_out_is_compl = compl_p2;
    assign bus.o_out_len      = len_p2;
    assign o_busy             = vld_p1 | vld_p2;
endmodule
